bird_renderer: RTL and testbench

//  Pixel-colour source feeding the VGA/HDMI output stage. Consumes the scan position
//  (x_pix/y_pix) and returns red/green/blue for that pixel.

---
 rtl/bird_renderer.sv | 223 ++++++++++++++++++++++
 tb/tb_bird_renderer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bird_renderer.sv
// -----------------------------------------------------------------------------
// bird_renderer
//   Pixel-colour source for the VGA/HDMI output stage. It also holds the
//   bird game state: position/velocity physics advanced once per frame, and an
//   IDLE/FLYING/DEAD state machine driven by the flap input.
//
//   Ports
//     clk        in   1   pixel clock (25 MHz VGA domain)
//     rst        in   1   synchronous, active-high reset (wins over everything)
//     x_pix      in  10   current scan column (0..800)
//     y_pix      in  10   current scan row (0..525)
//     flap       in   1   flap request
//     red        out  8   pixel red, registered (1-cycle render latency)
//     green      out  8   pixel green, registered
//     blue       out  8   pixel blue, registered
//     bird_y     out 10   current bird top row
//     game_state out  2   0=IDLE 1=FLYING 2=DEAD
//     frame_tick out  1   one-cycle pulse on the first cycle at (0,480)
//
//   Build option
//     BIRD_FLAP_SYNC_EN : when defined, flap is treated as an asynchronous
//     button (two-flop synchroniser + rising-edge detect, one request per
//     press, 3 cycles from press to pending). When undefined, flap is a
//     clk-synchronous level and every high cycle sets the pending flag.
// -----------------------------------------------------------------------------
module bird_renderer #(
   parameter int BIRD_X    = 160,
   parameter int BIRD_SIZE = 16,
   parameter int START_Y   = 200,
   parameter int FLOOR_Y   = 440,
   parameter int GRAVITY   = 1,
   parameter int FLAP_VEL  = 8,
   parameter int MAX_FALL  = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] x_pix,
   input  logic [9:0] y_pix,
   input  logic       flap,
   output logic [7:0] red,
   output logic [7:0] green,
   output logic [7:0] blue,
   output logic [9:0] bird_y,
   output logic [1:0] game_state,
   output logic       frame_tick
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FLYING = 2'd1;
   localparam logic [1:0] ST_DEAD   = 2'd2;

   localparam logic signed [7:0]  GRAV_S     = 8'(GRAVITY);
   localparam logic signed [7:0]  FLAP_S     = 8'(FLAP_VEL);
   localparam logic signed [7:0]  MAX_FALL_S = 8'(MAX_FALL);
   localparam logic signed [10:0] START_S    = 11'(START_Y);
   localparam logic signed [10:0] LAND_S     = 11'(FLOOR_Y - BIRD_SIZE);

   localparam logic [23:0] RGB_BLACK  = 24'h00_00_00;
   localparam logic [23:0] RGB_BIRD   = 24'hFF_D0_00;
   localparam logic [23:0] RGB_GROUND = 24'hDE_D8_95;
   localparam logic [23:0] RGB_SKY    = 24'h70_C5_CE;

   logic              match_s;
   logic              match_d_r;
   logic              tick_s;
   logic              flap_req_s;
   logic              pend_r;
   logic              pend_eff_s;
   logic [1:0]        state_r;
   logic [1:0]        state_nx_s;
   logic signed [7:0] vel_r;
   logic signed [7:0] vel_nx_s;
   logic signed [7:0] vel_fly_s;
   logic signed [10:0] y_r;
   logic signed [10:0] y_nx_s;
   logic signed [10:0] y_sum_s;
   logic [10:0]       bird_bot_s;
   logic [23:0]       rgb_nx_s;
   logic [23:0]       rgb_r;

   // Flap request source: raw synchronous level, or a synchronised press edge.
`ifdef BIRD_FLAP_SYNC_EN
   logic flap_meta_r;
   logic flap_sync_r;
   logic flap_prev_r;

   // Two-flop synchroniser followed by a delay flop for rising-edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         flap_meta_r <= 1'b0;
         flap_sync_r <= 1'b0;
         flap_prev_r <= 1'b0;
      end else begin
         flap_meta_r <= flap;
         flap_sync_r <= flap_meta_r;
         flap_prev_r <= flap_sync_r;
      end
   end

   assign flap_req_s = flap_sync_r & ~flap_prev_r;
`else
   assign flap_req_s = flap;
`endif

   // The tick is the rising edge of the (0,480) match, so holding the scan
   // position there produces only one pulse.
   assign match_s    = (x_pix == 10'd0) && (y_pix == 10'd480);
   assign tick_s     = match_s & ~match_d_r & ~rst;
   // A request arriving in the tick cycle itself is honoured by that tick.
   assign pend_eff_s = pend_r | flap_req_s;

   // Next bird state, only meaningful in the tick cycle; holds otherwise.
   always_comb begin
      state_nx_s = state_r;
      vel_nx_s   = vel_r;
      y_nx_s     = y_r;
      if (pend_eff_s) begin
         vel_fly_s = -FLAP_S;
      end else if (vel_r >= (MAX_FALL_S - GRAV_S)) begin
         vel_fly_s = MAX_FALL_S;
      end else begin
         vel_fly_s = vel_r + GRAV_S;
      end
      y_sum_s = y_r + {{3{vel_fly_s[7]}}, vel_fly_s};
      if (tick_s) begin
         case (state_r)
            ST_IDLE: begin
               if (pend_eff_s) begin
                  state_nx_s = ST_FLYING;
                  vel_nx_s   = -FLAP_S;
                  y_nx_s     = START_S - {{3{FLAP_S[7]}}, FLAP_S};
               end else begin
                  state_nx_s = ST_IDLE;
               end
            end
            ST_FLYING: begin
               if (y_sum_s < 11'sd0) begin
                  y_nx_s   = 11'sd0;
                  vel_nx_s = 8'sd0;
               end else if (y_sum_s >= LAND_S) begin
                  y_nx_s     = LAND_S;
                  vel_nx_s   = 8'sd0;
                  state_nx_s = ST_DEAD;
               end else begin
                  y_nx_s   = y_sum_s;
                  vel_nx_s = vel_fly_s;
               end
            end
            ST_DEAD: begin
               if (pend_eff_s) begin
                  state_nx_s = ST_IDLE;
                  y_nx_s     = START_S;
                  vel_nx_s   = 8'sd0;
               end else begin
                  state_nx_s = ST_DEAD;
               end
            end
            default: begin
               state_nx_s = ST_IDLE;
               y_nx_s     = START_S;
               vel_nx_s   = 8'sd0;
            end
         endcase
      end else begin
         state_nx_s = state_r;
      end
   end

   // Game state registers; position only moves on the tick (inside blanking).
   always_ff @(posedge clk) begin
      if (rst) begin
         match_d_r <= 1'b0;
         pend_r    <= 1'b0;
         state_r   <= ST_IDLE;
         vel_r     <= 8'sd0;
         y_r       <= START_S;
      end else begin
         match_d_r <= match_s;
         state_r   <= state_nx_s;
         vel_r     <= vel_nx_s;
         y_r       <= y_nx_s;
         if (tick_s) begin
            pend_r <= 1'b0;
         end else begin
            pend_r <= pend_r | flap_req_s;
         end
      end
   end

   assign bird_bot_s = {1'b0, y_r[9:0]} + 11'(BIRD_SIZE);

   // Pixel colour, first matching layer wins.
   always_comb begin
      rgb_nx_s = RGB_SKY;
      if ((x_pix >= 10'd640) || (y_pix >= 10'd480)) begin
         rgb_nx_s = RGB_BLACK;
      end else if ((x_pix >= 10'(BIRD_X)) && (x_pix < 10'(BIRD_X + BIRD_SIZE)) &&
                   (y_pix >= y_r[9:0]) && ({1'b0, y_pix} < bird_bot_s)) begin
         rgb_nx_s = RGB_BIRD;
      end else if (y_pix >= 10'(FLOOR_Y)) begin
         rgb_nx_s = RGB_GROUND;
      end else begin
         rgb_nx_s = RGB_SKY;
      end
   end

   // Registered colour output.
   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_r <= 24'h00_00_00;
      end else begin
         rgb_r <= rgb_nx_s;
      end
   end

   assign red        = rgb_r[23:16];
   assign green      = rgb_r[15:8];
   assign blue       = rgb_r[7:0];
   assign bird_y     = y_r[9:0];
   assign game_state = state_r;
   assign frame_tick = tick_s;

endmodule

// File: tb/tb_bird_renderer.sv
// -----------------------------------------------------------------------------
// tb_bird_renderer
//   Scoreboard bench for bird_renderer (default build, synchronous flap).
//   The driver applies one (x,y,flap,rst) per cycle, asks a game model for the
//   expected tick/state/position of that cycle and the colour the pixel should
//   have, and pushes that record. A monitor pops one record per cycle and
//   compares; the colour is compared one cycle later (render latency).
// -----------------------------------------------------------------------------
module tb_bird_renderer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] x_pix = 10'd0;
   logic [9:0] y_pix = 10'd0;
   logic       flap = 1'b0;
   logic [7:0] red, green, blue;
   logic [9:0] bird_y;
   logic [1:0] game_state;
   logic       frame_tick;

   bird_renderer dut (
      .clk(clk), .rst(rst), .x_pix(x_pix), .y_pix(y_pix), .flap(flap),
      .red(red), .green(green), .blue(blue), .bird_y(bird_y),
      .game_state(game_state), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          tick;
      int          by;
      int          st;
      logic [23:0] rgb;
   } rec_t;

   rec_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Game model: integers and plain rules
   int m_state = 0;   // 0 idle, 1 flying, 2 dead
   int m_y     = 200;
   int m_vel   = 0;
   bit m_pend  = 1'b0;
   bit m_prev_match = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] colour(input int xi, input int yi, input int by);
      if (xi >= 640 || yi >= 480) return 24'h000000;
      if (xi >= 160 && xi < 176 && yi >= by && yi < by + 16) return 24'hFFD000;
      if (yi >= 440) return 24'hDED895;
      return 24'h70C5CE;
   endfunction

   task automatic model_step(input bit rs, input bit fl, input bit tk);
      bit p;
      if (rs) begin
         m_state = 0; m_y = 200; m_vel = 0; m_pend = 1'b0;
      end else if (tk) begin
         p = m_pend | fl;
         m_pend = 1'b0;
         if (m_state == 0) begin
            if (p) begin m_state = 1; m_vel = -8; m_y = 200 - 8; end
         end else if (m_state == 1) begin
            m_vel = p ? -8 : ((m_vel + 1 > 10) ? 10 : m_vel + 1);
            m_y = m_y + m_vel;
            if (m_y < 0) begin
               m_y = 0; m_vel = 0;
            end else if (m_y >= 424) begin
               m_y = 424; m_vel = 0; m_state = 2;
            end
         end else begin
            if (p) begin m_state = 0; m_y = 200; m_vel = 0; end
         end
      end else begin
         m_pend = m_pend | fl;
      end
   endtask

   task automatic cycle(input int xi, input int yi, input bit fl, input bit rs);
      rec_t r;
      bit   match;
      logic [9:0] xv, yv;
      @(posedge clk);
      #1;
      xv = xi[9:0];
      yv = yi[9:0];
      x_pix = xv; y_pix = yv; flap = fl; rst = rs;
      match  = (xi == 0 && yi == 480);
      r.tick = !rs && match && !m_prev_match;
      r.by   = m_y;
      r.st   = m_state;
      r.rgb  = rs ? 24'h000000 : colour(xi, yi, m_y);
      sb_q.push_back(r);
      model_step(rs, fl, r.tick);
      m_prev_match = rs ? 1'b0 : match;
   endtask

   task automatic tick(input bit fl);
      cycle(0, 480, fl, 1'b0);
      cycle(7, 480, 1'b0, 1'b0);
   endtask

   // Monitor: one record per cycle; colour lags its record by one cycle.
   initial begin : monitor
      rec_t r;
      rec_t prev;
      bit   have_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            chk("frame_tick", {31'd0, frame_tick}, {31'd0, r.tick});
            chk("bird_y", {22'd0, bird_y}, r.by);
            chk("game_state", {30'd0, game_state}, r.st);
            if (have_prev) chk("rgb", {8'd0, red, green, blue}, {8'd0, prev.rgb});
            prev = r;
            have_prev = 1'b1;
         end
      end
   end

   initial begin : stim
      int sel, xi, yi;
      bit fl, rs;
      // reset, two cycles
      cycle(0, 0, 1'b0, 1'b1);
      cycle(0, 0, 1'b0, 1'b1);
      // render points in IDLE
      cycle(160, 200, 1'b0, 1'b0);
      cycle(100, 100, 1'b0, 1'b0);
      cycle(10, 450, 1'b0, 1'b0);
      cycle(700, 10, 1'b0, 1'b0);
      cycle(175, 215, 1'b0, 1'b0);
      cycle(176, 215, 1'b0, 1'b0);
      cycle(160, 216, 1'b0, 1'b0);
      cycle(639, 479, 1'b0, 1'b0);
      // flap pulse then three ticks: 192, 185, 179
      cycle(50, 50, 1'b1, 1'b0);
      cycle(50, 50, 1'b0, 1'b0);
      tick(1'b0);
      tick(1'b0);
      tick(1'b0);
      // fall until dead, then further ticks stay at 424
      for (int i = 0; i < 40; i++) tick(1'b0);
      cycle(165, 430, 1'b0, 1'b0);
      // dead + flap -> idle
      cycle(20, 20, 1'b1, 1'b0);
      tick(1'b0);
      // flap in the tick cycle itself, then keep flapping to the ceiling
      tick(1'b1);
      for (int i = 0; i < 30; i++) tick(1'b1);
      cycle(165, 0, 1'b0, 1'b0);
      // rst and flap together: pending discarded
      cycle(30, 30, 1'b1, 1'b1);
      tick(1'b0);
      // holding the match position gives one tick only
      for (int i = 0; i < 5; i++) cycle(0, 480, 1'b0, 1'b0);
      cycle(0, 479, 1'b0, 1'b0);
      // randomized play
      for (int i = 0; i < 3000; i++) begin
         sel = $urandom_range(0, 99);
         fl  = ($urandom_range(0, 19) == 0);
         rs  = (sel < 1);
         if (sel < 10) begin
            xi = 0; yi = 480;
         end else if (sel < 50) begin
            xi = $urandom_range(150, 185);
            yi = m_y + $urandom_range(0, 22) - 3;
            if (yi < 0) yi = 0;
         end else begin
            xi = $urandom_range(0, 800);
            yi = $urandom_range(0, 525);
         end
         cycle(xi, yi, fl, rs);
      end
      cycle(300, 300, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      chk("scoreboard_drained", sb_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
